bus_master_irq_ctrl: RTL and testbench

Processor-side bus master for the shared 8-bit peripheral bus. It turns single core requests into bus write and read cycles, and drives the BUS_DATA tristate on writes. It also samples peripheral interrupt-raise lines, prioritises them, presents one vector to the core, and returns the per-line ACK pulse. It is the counterpart of memory-mapped target peripherals such as the timer at 0xF0–0xF3.

---
 rtl/bus_master_irq_ctrl.sv | 152 +++++++++++++++
 tb/tb_bus_master_irq_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_master_irq_ctrl.sv
// Core-side master for the shared 8-bit peripheral bus.
// Also prioritises peripheral interrupt lines and returns per-line ACK pulses.
module bus_master_irq_ctrl #(
  parameter int          NUM_IRQ   = 2,
  parameter int          READ_WAIT = 1,
  parameter logic [7:0]  IDLE_ADDR = 8'hFF
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               CORE_REQ,
  input  logic               CORE_WE,
  input  logic [7:0]         CORE_ADDR,
  input  logic [7:0]         CORE_WDATA,
  output logic [7:0]         CORE_RDATA,
  output logic               CORE_DONE,
  output logic               CORE_BUSY,
  output logic               IRQ_PENDING,
  output logic [1:0]         IRQ_ID,
  input  logic               IRQ_TAKEN,
  inout  wire  [7:0]         BUS_DATA,
  output logic [7:0]         BUS_ADDR,
  output logic               BUS_WE,
  input  logic [NUM_IRQ-1:0] BUS_INTERRUPTS_RAISE,
  output logic [NUM_IRQ-1:0] BUS_INTERRUPTS_ACK
);

  localparam int CW = (READ_WAIT < 1) ? 1 : $clog2(READ_WAIT + 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ, TURN} state_t;

  state_t          state_reg;
  logic [CW-1:0]   wait_reg;
  logic [7:0]      addr_reg;
  logic [7:0]      wdata_reg;
  logic [7:0]      rdata_reg;
  logic            we_reg;
  logic            drive_reg;
  logic            done_reg;

  logic [NUM_IRQ-1:0] inflight_reg;
  logic [NUM_IRQ-1:0] ack_reg;
  logic [NUM_IRQ-1:0] ack_d_reg;
  logic [NUM_IRQ-1:0] avail;
  logic               pend_reg;
  logic [1:0]         id_reg;
  logic               sel_valid;
  logic [1:0]         sel_id;
  logic               take;

  // Bus transaction sequencer
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg <= IDLE;
      wait_reg  <= '0;
      addr_reg  <= IDLE_ADDR;
      wdata_reg <= 8'h00;
      rdata_reg <= 8'h00;
      we_reg    <= 1'b0;
      drive_reg <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      unique case (state_reg)
        IDLE: begin
          if (CORE_REQ) begin
            addr_reg  <= CORE_ADDR;
            wdata_reg <= CORE_WDATA;
            if (CORE_WE) begin
              we_reg    <= 1'b1;
              drive_reg <= 1'b1;
              state_reg <= WRITE;
            end else begin
              wait_reg  <= CW'(READ_WAIT);
              state_reg <= READ;
            end
          end
        end
        WRITE: begin
          we_reg    <= 1'b0;
          drive_reg <= 1'b0;
          addr_reg  <= IDLE_ADDR;
          done_reg  <= 1'b1;
          state_reg <= IDLE;
        end
        READ: begin
          if (wait_reg == '0) begin
            rdata_reg <= BUS_DATA;
            addr_reg  <= IDLE_ADDR;
            state_reg <= TURN;
          end else begin
            wait_reg <= wait_reg - CW'(1);
          end
        end
        TURN: begin
          // Dead cycle lets the target's registered drive release first
          done_reg  <= 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign BUS_DATA   = drive_reg ? wdata_reg : 8'hzz;
  assign BUS_ADDR   = addr_reg;
  assign BUS_WE     = we_reg;
  assign CORE_RDATA = rdata_reg;
  assign CORE_DONE  = done_reg;
  assign CORE_BUSY  = (state_reg != IDLE);

  // Lowest available index wins
  always_comb begin
    avail     = BUS_INTERRUPTS_RAISE & ~inflight_reg;
    sel_valid = 1'b0;
    sel_id    = 2'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (avail[i]) begin
        sel_valid = 1'b1;
        sel_id    = 2'(i);
      end
    end
  end

  assign take = IRQ_TAKEN && pend_reg;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pend_reg     <= 1'b0;
      id_reg       <= 2'd0;
      ack_reg      <= '0;
      ack_d_reg    <= '0;
      inflight_reg <= '0;
    end else begin
      pend_reg  <= sel_valid;
      id_reg    <= sel_id;
      ack_d_reg <= ack_reg;
      for (int i = 0; i < NUM_IRQ; i++) begin
        ack_reg[i] <= take && (id_reg == 2'(i));
        // A line stays masked until two cycles after its ACK pulse
        if (take && (id_reg == 2'(i)))
          inflight_reg[i] <= 1'b1;
        else if (ack_d_reg[i])
          inflight_reg[i] <= 1'b0;
      end
    end
  end

  assign IRQ_PENDING        = pend_reg;
  assign IRQ_ID             = id_reg;
  assign BUS_INTERRUPTS_ACK = ack_reg;

endmodule

// File: tb/tb_bus_master_irq_ctrl.sv
// Bench for bus_master_irq_ctrl: transaction-timeline model plus interrupt
// masking-window model, compared every cycle, with directed literal checks.
module tb_bus_master_irq_ctrl;
  localparam int         NUM_IRQ   = 2;
  localparam int         READ_WAIT = 1;
  localparam logic [7:0] TGT_ADDR  = 8'hF0;

  logic               CLK = 1'b0;
  logic               RESET = 1'b1;
  logic               CORE_REQ = 1'b0;
  logic               CORE_WE = 1'b0;
  logic [7:0]         CORE_ADDR = 8'h00;
  logic [7:0]         CORE_WDATA = 8'h00;
  logic [7:0]         CORE_RDATA;
  logic               CORE_DONE;
  logic               CORE_BUSY;
  logic               IRQ_PENDING;
  logic [1:0]         IRQ_ID;
  logic               IRQ_TAKEN = 1'b0;
  wire  [7:0]         bus_data;
  logic [7:0]         BUS_ADDR;
  logic               BUS_WE;
  logic [NUM_IRQ-1:0] RAISE = '0;
  logic [NUM_IRQ-1:0] ACK;

  bus_master_irq_ctrl #(.NUM_IRQ(NUM_IRQ), .READ_WAIT(READ_WAIT), .IDLE_ADDR(8'hFF)) dut (
    .CLK(CLK), .RESET(RESET),
    .CORE_REQ(CORE_REQ), .CORE_WE(CORE_WE), .CORE_ADDR(CORE_ADDR), .CORE_WDATA(CORE_WDATA),
    .CORE_RDATA(CORE_RDATA), .CORE_DONE(CORE_DONE), .CORE_BUSY(CORE_BUSY),
    .IRQ_PENDING(IRQ_PENDING), .IRQ_ID(IRQ_ID), .IRQ_TAKEN(IRQ_TAKEN),
    .BUS_DATA(bus_data), .BUS_ADDR(BUS_ADDR), .BUS_WE(BUS_WE),
    .BUS_INTERRUPTS_RAISE(RAISE), .BUS_INTERRUPTS_ACK(ACK)
  );

  always #5 CLK = ~CLK;

  // Simple registered read target at TGT_ADDR
  logic       tgt_en = 1'b0;
  logic [7:0] tgt_val = 8'h5A;
  always @(posedge CLK) tgt_en <= (BUS_ADDR == TGT_ADDR) && !BUS_WE;
  assign bus_data = tgt_en ? tgt_val : 8'hzz;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, expv);
    end
  endtask

  // ---------------- model ----------------
  typedef struct {
    logic [7:0] addr;
    logic       we;
    logic       drv;
    logic [7:0] data;
    logic       cap;
    logic       done_after;
  } slot_t;

  slot_t              tl[$];
  bit                 model_valid = 1'b0;
  int                 cyc = 0;
  int                 take_edge[NUM_IRQ];
  logic               exp_done = 1'b0;
  logic [7:0]         exp_rdata = 8'h00;
  logic               exp_pend = 1'b0;
  logic [1:0]         exp_id = 2'd0;
  logic [NUM_IRQ-1:0] exp_ack = '0;

  task automatic model_step();
    slot_t              s;
    logic [NUM_IRQ-1:0] av;
    logic [NUM_IRQ-1:0] nack;
    if (RESET) begin
      tl.delete();
      exp_done  = 1'b0;
      exp_rdata = 8'h00;
      exp_pend  = 1'b0;
      exp_id    = 2'd0;
      exp_ack   = '0;
      for (int i = 0; i < NUM_IRQ; i++) take_edge[i] = -100;
      model_valid = 1'b1;
    end else begin
      exp_done = 1'b0;
      if (tl.size() != 0) begin
        s = tl.pop_front();
        if (s.cap) exp_rdata = tgt_val;
        if (s.done_after) exp_done = 1'b1;
      end else if (CORE_REQ) begin
        if (CORE_WE) begin
          tl.push_back('{CORE_ADDR, 1'b1, 1'b1, CORE_WDATA, 1'b0, 1'b1});
        end else begin
          for (int k = 0; k <= READ_WAIT; k++)
            tl.push_back('{CORE_ADDR, 1'b0, 1'b0, 8'h00, (k == READ_WAIT), 1'b0});
          tl.push_back('{8'hFF, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1});
        end
      end
      nack = '0;
      for (int i = 0; i < NUM_IRQ; i++)
        av[i] = RAISE[i] && !(cyc > take_edge[i] && cyc <= take_edge[i] + 2);
      if (IRQ_TAKEN && exp_pend) begin
        nack[int'(exp_id)] = 1'b1;
        take_edge[int'(exp_id)] = cyc;
      end
      exp_pend = |av;
      exp_id   = 2'd0;
      for (int i = NUM_IRQ - 1; i >= 0; i--)
        if (av[i]) exp_id = 2'(i);
      exp_ack = nack;
    end
    cyc++;
  endtask

  initial forever begin
    @(posedge CLK);
    model_step();
  end

  // Per-cycle compare against the model
  initial forever begin
    @(negedge CLK);
    if (model_valid) begin
      logic [7:0] ea;
      logic       ew;
      logic       eb;
      ea = 8'hFF; ew = 1'b0; eb = (tl.size() != 0);
      if (eb) begin
        ea = tl[0].addr;
        ew = tl[0].we;
        if (tl[0].drv) chk("bus_wdata", 32'(bus_data), 32'(tl[0].data));
      end
      chk("bus_addr_we_busy", {22'd0, BUS_ADDR, BUS_WE, CORE_BUSY}, {22'd0, ea, ew, eb});
      chk("core_done_rdata", {23'd0, CORE_DONE, CORE_RDATA}, {23'd0, exp_done, exp_rdata});
      chk("irq_pend_id_ack", 32'({IRQ_PENDING, IRQ_ID, ACK}), 32'({exp_pend, exp_id, exp_ack}));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    tick(3);
    RESET = 1'b0;
    chk("rst_addr", 32'(BUS_ADDR), 32'h0000_00FF);
    chk("rst_busy", 32'(CORE_BUSY), 32'd0);
    chk("rst_pend", 32'(IRQ_PENDING), 32'd0);
    tick();

    // Write F1 <- 32
    CORE_REQ = 1'b1; CORE_WE = 1'b1; CORE_ADDR = 8'hF1; CORE_WDATA = 8'h32;
    tick();
    CORE_REQ = 1'b0;
    chk("wr_addr", 32'(BUS_ADDR), 32'h0000_00F1);
    chk("wr_we", 32'(BUS_WE), 32'd1);
    chk("wr_data", 32'(bus_data), 32'h0000_0032);
    tick();
    chk("wr_done", 32'(CORE_DONE), 32'd1);
    chk("wr_idle_addr", 32'(BUS_ADDR), 32'h0000_00FF);
    tick();
    chk("wr_done_pulse", 32'(CORE_DONE), 32'd0);

    // Read F0, then a write request during TURN which must wait
    tgt_val = 8'h5A;
    CORE_REQ = 1'b1; CORE_WE = 1'b0; CORE_ADDR = 8'hF0;
    tick();
    CORE_REQ = 1'b0;
    chk("rd_addr", 32'(BUS_ADDR), 32'h0000_00F0);
    tick();
    chk("rd_hold", 32'(BUS_ADDR), 32'h0000_00F0);
    tick();
    chk("rd_capture", 32'(CORE_RDATA), 32'h0000_005A);
    chk("rd_turn_busy", 32'(CORE_BUSY), 32'd1);
    CORE_REQ = 1'b1; CORE_WE = 1'b1; CORE_ADDR = 8'hF2; CORE_WDATA = 8'hA5;
    tick();
    chk("rd_done", 32'(CORE_DONE), 32'd1);
    chk("turn_req_ignored", 32'(CORE_BUSY), 32'd0);
    tick();
    CORE_REQ = 1'b0;
    chk("b2b_wr_addr", 32'(BUS_ADDR), 32'h0000_00F2);
    chk("b2b_wr_data", 32'(bus_data), 32'h0000_00A5);
    tick(2);

    // Two lines raised, taken in priority order
    RAISE = 2'b11;
    tick();
    chk("irq_first_id", 32'({IRQ_PENDING, IRQ_ID}), 32'({1'b1, 2'd0}));
    IRQ_TAKEN = 1'b1;
    tick();
    IRQ_TAKEN = 1'b0;
    chk("irq_ack0", 32'(ACK), 32'b01);
    tick();
    chk("irq_ack0_pulse", 32'(ACK), 32'b00);
    chk("irq_second_id", 32'({IRQ_PENDING, IRQ_ID}), 32'({1'b1, 2'd1}));
    IRQ_TAKEN = 1'b1;
    tick();
    IRQ_TAKEN = 1'b0;
    chk("irq_ack1", 32'(ACK), 32'b10);
    tick();
    chk("irq_ack1_pulse", 32'(ACK), 32'b00);
    RAISE = 2'b00;
    tick(4);

    // Line 0 held: re-pends three cycles after its ACK cycle
    RAISE = 2'b01;
    tick();
    IRQ_TAKEN = 1'b1;
    tick();
    IRQ_TAKEN = 1'b0;
    chk("hold_ack", 32'(ACK), 32'b01);
    tick();
    chk("hold_masked1", 32'(IRQ_PENDING), 32'd0);
    tick();
    chk("hold_masked2", 32'(IRQ_PENDING), 32'd0);
    tick();
    chk("hold_repend", 32'({IRQ_PENDING, IRQ_ID}), 32'({1'b1, 2'd0}));
    tick(6);
    RAISE = 2'b00;
    tick(4);

    // Higher-priority line rises in the same cycle as TAKEN
    RAISE = 2'b10;
    tick();
    RAISE = 2'b11;
    IRQ_TAKEN = 1'b1;
    tick();
    IRQ_TAKEN = 1'b0;
    chk("race_ack_old", 32'(ACK), 32'b10);
    chk("race_new_id", 32'(IRQ_ID), 32'd0);
    RAISE = 2'b00;
    tick(4);

    // Reset in the middle of a read
    CORE_REQ = 1'b1; CORE_WE = 1'b0; CORE_ADDR = 8'hF0;
    tick();
    CORE_REQ = 1'b0;
    tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("midrst_addr_we", 32'({BUS_ADDR, BUS_WE}), 32'({8'hFF, 1'b0}));
    chk("midrst_done_ack", 32'({CORE_DONE, CORE_BUSY, ACK}), 32'd0);
    tick();
    chk("midrst_no_done", 32'(CORE_DONE), 32'd0);

    // Normal read afterwards, with an interrupt taken concurrently
    tgt_val = 8'hC3;
    RAISE = 2'b01;
    CORE_REQ = 1'b1; CORE_WE = 1'b0; CORE_ADDR = 8'hF0;
    tick();
    CORE_REQ = 1'b0;
    IRQ_TAKEN = 1'b1;
    tick();
    IRQ_TAKEN = 1'b0;
    chk("conc_ack", 32'(ACK), 32'b01);
    tick(2);
    chk("rerd_done_data", 32'({CORE_DONE, CORE_RDATA}), 32'({1'b1, 8'hC3}));
    RAISE = 2'b00;
    tick(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
